// File: rtl/seq_pkg.sv
// Shared types and helpers for the memory-game sequence register.
// Symbol 0 sits in the most significant slot of the packed sequence.
package seq_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        PLAY = 1'b1
    } seq_state_t;

    localparam int unsigned SEQ_SYM_W = 4;
    localparam int unsigned SEQ_DEPTH = 16;

    // LSB bit position of slot idx inside a depth*sym_w packed vector
    function automatic int unsigned slot_lsb(input int unsigned idx,
                                             input int unsigned sym_w,
                                             input int unsigned depth);
        return (depth - 1 - idx) * sym_w;
    endfunction

endpackage

// File: rtl/seq_round_checker.sv
// Compares player symbols against the stored sequence, one registered
// ok/miss pulse per accepted input; only built with SEQ_ROUND_CHECK_EN.
module seq_round_checker
    import seq_pkg::*;
#(
    parameter int SYM_W  = SEQ_SYM_W,
    parameter int DEPTH  = SEQ_DEPTH,
    parameter int DATA_W = SYM_W * DEPTH,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              R,
    input  logic [DATA_W-1:0] q,
    input  logic [CNT_W-1:0]  round,
    input  logic              busy,
    input  logic              ptr_clr,
    input  logic              chk_valid,
    input  logic [SYM_W-1:0]  chk_sym,
    output logic              chk_ok,
    output logic              chk_miss,
    output logic              chk_done
);

    logic [CNT_W-1:0] chk_ptr;
    logic [SYM_W-1:0] exp_sym;
    logic             chk_take;

    assign exp_sym  = q[slot_lsb(32'(chk_ptr), SYM_W, DEPTH) +: SYM_W];
    assign chk_take = chk_valid && !busy && (round != '0) && !ptr_clr;

    always_ff @(posedge clk or negedge R) begin
        if (!R) begin
            chk_ptr  <= '0;
            chk_ok   <= 1'b0;
            chk_miss <= 1'b0;
            chk_done <= 1'b0;
        end else begin
            chk_ok   <= 1'b0;
            chk_miss <= 1'b0;
            chk_done <= 1'b0;
            if (ptr_clr) begin
                chk_ptr <= '0;
            end else if (chk_take) begin
                if (chk_sym == exp_sym) begin
                    chk_ok <= 1'b1;
                    if (chk_ptr == round - CNT_W'(1)) begin
                        chk_done <= 1'b1;
                        chk_ptr  <= '0;
                    end else begin
                        chk_ptr <= chk_ptr + CNT_W'(1);
                    end
                end else begin
                    chk_miss <= 1'b1;
                    chk_ptr  <= '0;
                end
            end
        end
    end

endmodule

// File: rtl/seq_round_reg.sv
// Sequence register: append/parallel-load of round symbols and valid/ready replay.
// Optional answer checker enabled by defining SEQ_ROUND_CHECK_EN.
module seq_round_reg
    import seq_pkg::*;
#(
    parameter  int SYM_W  = SEQ_SYM_W,
    parameter  int DEPTH  = SEQ_DEPTH,
    localparam int DATA_W = SYM_W * DEPTH,
    localparam int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              R,
    input  logic              E,
    input  logic [DATA_W-1:0] data,
    input  logic              clr,
    input  logic              app,
    input  logic [SYM_W-1:0]  sym_in,
    input  logic              play_start,
    input  logic              play_rdy,
`ifdef SEQ_ROUND_CHECK_EN
    input  logic              chk_valid,
    input  logic [SYM_W-1:0]  chk_sym,
    output logic              chk_ok,
    output logic              chk_miss,
    output logic              chk_done,
`endif
    output logic [DATA_W-1:0] q,
    output logic [SYM_W-1:0]  sym_first,
    output logic [CNT_W-1:0]  round,
    output logic              full,
    output logic              ovf,
    output logic              busy,
    output logic              play_valid,
    output logic [SYM_W-1:0]  play_sym,
    output logic              play_last
);

    seq_state_t       state;
    logic [CNT_W-1:0] ptr;

    assign sym_first  = q[DATA_W-1 -: SYM_W];
    assign full       = (round == CNT_W'(DEPTH));
    assign busy       = (state == PLAY);
    assign play_valid = (state == PLAY);
    assign play_sym   = (state == PLAY) ? q[slot_lsb(32'(ptr), SYM_W, DEPTH) +: SYM_W] : '0;
    assign play_last  = (state == PLAY) && (ptr == round - CNT_W'(1));

    always_ff @(posedge clk or negedge R) begin
        if (!R) begin
            state <= IDLE;
            q     <= '0;
            round <= '0;
            ptr   <= '0;
            ovf   <= 1'b0;
        end else begin
            ovf <= 1'b0;
            case (state)
                IDLE: begin
                    if (clr) begin
                        q     <= '0;
                        round <= '0;
                    end else if (E) begin
                        q     <= data;
                        round <= CNT_W'(DEPTH);
                    end else if (app) begin
                        if (!full) begin
                            q[slot_lsb(32'(round), SYM_W, DEPTH) +: SYM_W] <= sym_in;
                            round <= round + CNT_W'(1);
                        end else begin
                            ovf <= 1'b1;
                        end
                    end else if (play_start && (round != '0)) begin
                        ptr   <= '0;
                        state <= PLAY;
                    end
                end
                PLAY: begin
                    if (play_rdy) begin
                        if (play_last) state <= IDLE;
                        else           ptr   <= ptr + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef SEQ_ROUND_CHECK_EN
    logic chk_ptr_clr;

    // Any change to the stored sequence restarts the player's answer
    assign chk_ptr_clr = (state == IDLE) && (clr || E || (app && !full));

    seq_round_checker #(
        .SYM_W (SYM_W),
        .DEPTH (DEPTH),
        .DATA_W(DATA_W),
        .CNT_W (CNT_W)
    ) u_checker (
        .clk      (clk),
        .R        (R),
        .q        (q),
        .round    (round),
        .busy     (busy),
        .ptr_clr  (chk_ptr_clr),
        .chk_valid(chk_valid),
        .chk_sym  (chk_sym),
        .chk_ok   (chk_ok),
        .chk_miss (chk_miss),
        .chk_done (chk_done)
    );
`endif

endmodule

// File: doc/seq_round_reg.md
Name: seq_round_reg

Overview:
- Parametrised sequence register for the memory-game datapath. Builds the round's correct sequence one symbol per round (append) or takes a full-width parallel load.
- Replays the stored symbols in order through a valid/ready stream for the display/sound stage.
- Sits between the random-symbol generator and the playback/compare logic. Successor to the fixed 64-bit latch-style sequence register.

Parameters:
- SYM_W, 4, bits per symbol
- DEPTH, 16, maximum symbols (rounds) stored
- DATA_W, SYM_W*DEPTH, derived width of the full sequence; not overridden
- CNT_W, $clog2(DEPTH+1), derived width of the round counter

Ports:
- clk  in  1  clock, all state on rising edge
- R  in  1  reset, asynchronous, active-low
- E  in  1  parallel-load enable
- data  in  DATA_W  parallel-load sequence
- clr  in  1  synchronous clear of the sequence (new game)
- app  in  1  append strobe
- sym_in  in  SYM_W  symbol to append
- play_start  in  1  start replay request
- play_rdy  in  1  consumer ready
- q  out  DATA_W  full stored sequence
- sym_first  out  SYM_W  symbol 0, i.e. q[DATA_W-1 -: SYM_W]
- round  out  CNT_W  number of valid symbols
- full  out  1  round==DEPTH
- ovf  out  1  one-cycle pulse: append attempted while full
- busy  out  1  replay in progress
- play_valid  out  1  play_sym valid
- play_sym  out  SYM_W  current replay symbol
- play_last  out  1  play_sym is the final symbol (round-1)

Behaviour:
- Layout: symbol i occupies q[DATA_W-1-i*SYM_W -: SYM_W], so symbol 0 is the most significant. Unused slots read 0.
- Reset (R=0, asynchronous): q=0, round=0, ovf=0, state=IDLE, ptr=0. All outputs are therefore 0.
- FSM states: IDLE, PLAY. All outputs are registered, except play_sym/play_last/play_valid, which decode from state+ptr with no added latency.
- IDLE, command priority in one cycle: clr > E > app > play_start.
  - clr: q=0, round=0.
  - E: q=data, round=DEPTH.
  - app with round<DEPTH: slot[round]=sym_in, round+=1; the result is visible the next cycle.
  - app with full: no change, ovf=1 for one cycle.
  - play_start with round>0: ptr=0, go to PLAY. With round==0 it is ignored and stays in IDLE.
- PLAY:
  - busy=1, play_valid=1, play_sym=slot[ptr], play_last=(ptr==round-1).
  - On play_valid&&play_rdy: if play_last, go to IDLE next cycle (play_valid low); otherwise ptr+=1.
  - play_sym holds stable while play_rdy=0.
  - clr, E, app and play_start are ignored in PLAY; ovf is not asserted.
  - One symbol per cycle with play_rdy held high. A replay of N symbols takes N cycles, plus one cycle to return to IDLE.
- Reset mid-replay: returns immediately to IDLE with everything cleared; there is no partial-replay state.
- round never exceeds DEPTH and never wraps.

Optional Feature:
- Macro SEQ_ROUND_CHECK_EN.
- When defined, adds the following ports:
  - in chk_valid (1)
  - in chk_sym (SYM_W)
  - out chk_ok (1)
  - out chk_miss (1)
  - out chk_done (1)
- Checker behaviour:
  - A checker pointer starts at 0.
  - Each chk_valid compares chk_sym with slot[chk_ptr]. The result is registered one cycle later as a one-cycle pulse on chk_ok or chk_miss.
  - On a match at chk_ptr==round-1, chk_done pulses with chk_ok and chk_ptr returns to 0. Any other match increments chk_ptr.
  - A miss resets chk_ptr to 0.
  - chk_ptr also resets on R, clr, E and successful app.
  - chk_valid is ignored while busy or round==0.
- When undefined: the ports and logic are absent.

Decomposition:
- Shared package seq_pkg holds:
  - the FSM state enum (IDLE, PLAY)
  - default SYM_W/DEPTH localparams
  - a slot-index-to-bit-offset helper function
- Natural sub-module: seq_round_checker, instantiated only under SEQ_ROUND_CHECK_EN.

Test Plan:
- Reset then idle, with defaults -> q=0, round=0, full=0, play_valid=0. Release R mid-cycle -> still 0.
- Append 4'h3, 4'hA, 4'h5 -> round=3, q[63:52]=12'h3A5, sym_first=4'h3, rest 0.
- E with data=64'h0123_4567_89AB_CDEF -> round=16, full=1. Then app -> ovf pulses one cycle, q unchanged.
- Replay of 3A5 with play_rdy=1 -> play_sym 3, A, 5 on consecutive cycles, play_last on 5, busy low the cycle after. Repeat with play_rdy toggling 1/0 -> each symbol held until accepted.
- Simultaneous clr+E+app in IDLE -> clr wins, round=0. app during PLAY -> ignored. Assert R during PLAY -> immediate IDLE with all outputs 0.
- (SEQ_ROUND_CHECK_EN) Sequence 3A5; inputs 3, A, 5 -> chk_ok ×3, chk_done with the third. Inputs 3, 7 -> chk_miss on the second; the next 3 is accepted as index 0.
